// File: rtl/calc_alu_pkg.sv
// calc_alu_pkg: shared definitions for the calc_alu block.
//   op_e           - opcode encoding (NOP, ADD, SUB, reserved)
//   DATA_W_DEFAULT - default operand width
package calc_alu_pkg;

    typedef enum logic [1:0] {
        OP_NOP = 2'b00,
        OP_ADD = 2'b01,
        OP_SUB = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    localparam int unsigned DATA_W_DEFAULT = 16;

endpackage

// File: rtl/calc_alu_addsub.sv
// calc_alu_addsub: combinational add / subtract datapath for calc_alu.
// Ports:
//   num1, num2 - unsigned operands (DATA_W bits)
//   sum        - zero-extended num1 + num2, carry in bit DATA_W
//   diff       - subtract result (DATA_W+1 bits), form selected by macro
//   neg        - 1 when num1 < num2
// Configuration macro CALC_ALU_SIGNMAG_EN:
//   defined   - diff is the magnitude |num1 - num2|, neg is its sign
//   undefined - diff is the (DATA_W+1)-bit two's complement of num1 - num2,
//               neg is the borrow
module calc_alu_addsub
    import calc_alu_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input  logic [DATA_W-1:0] num1,
    input  logic [DATA_W-1:0] num2,
    output logic [DATA_W:0]   sum,
    output logic [DATA_W:0]   diff,
    output logic              neg
);

    logic [DATA_W:0] a_ext;
    logic [DATA_W:0] b_ext;
    logic            borrow;

    assign a_ext  = {1'b0, num1};
    assign b_ext  = {1'b0, num2};
    assign borrow = (num1 < num2);
    assign sum    = a_ext + b_ext;
    assign neg    = borrow;

`ifdef CALC_ALU_SIGNMAG_EN
    // Swap operands on borrow so the result is always a non-negative magnitude;
    // bit DATA_W therefore stays 0.
    assign diff = borrow ? (b_ext - a_ext) : (a_ext - b_ext);
`else
    assign diff = a_ext - b_ext;
`endif

endmodule

// File: rtl/calc_alu.sv
// calc_alu: registered two-operand ADD/SUB unit.
// Ports:
//   clk            - clock, rising edge
//   clear          - asynchronous active-low reset
//   num1, num2     - unsigned operands (DATA_W bits), sampled every cycle
//   op_selected    - 00 NOP (hold), 01 ADD, 10 SUB, 11 reserved (load 0)
//   number_out     - registered result (DATA_W+1 bits)
//   special_signal - registered flag; set when a SUB has num1 < num2
// Configuration macro CALC_ALU_SIGNMAG_EN selects the SUB result form
// (see calc_alu_addsub).
module calc_alu
    import calc_alu_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              clear,
    input  logic [DATA_W-1:0] num1,
    input  logic [DATA_W-1:0] num2,
    input  logic [1:0]        op_selected,
    output logic [DATA_W:0]   number_out,
    output logic              special_signal
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;
    logic            neg;

    logic [DATA_W:0] out_d, out_q;
    logic            sign_d, sign_q;

    calc_alu_addsub #(
        .DATA_W (DATA_W)
    ) u_addsub (
        .num1 (num1),
        .num2 (num2),
        .sum  (sum),
        .diff (diff),
        .neg  (neg)
    );

    always_comb begin
        out_d  = out_q;
        sign_d = sign_q;
        unique case (op_selected)
            OP_NOP: begin
                out_d  = out_q;
                sign_d = sign_q;
            end
            OP_ADD: begin
                out_d  = sum;
                sign_d = 1'b0;
            end
            OP_SUB: begin
                out_d  = diff;
                sign_d = neg;
            end
            OP_RSV: begin
                out_d  = '0;
                sign_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            out_q  <= '0;
            sign_q <= 1'b0;
        end else begin
            out_q  <= out_d;
            sign_q <= sign_d;
        end
    end

    assign number_out     = out_q;
    assign special_signal = sign_q;

endmodule

// File: tb/tb_calc_alu.sv
module tb_calc_alu;

    localparam int unsigned W = 16;

    typedef struct {
        logic [W:0] out;
        logic       sign;
        string      name;
    } exp_t;

    logic           clk;
    logic           clear;
    logic [W-1:0]   num1;
    logic [W-1:0]   num2;
    logic [1:0]     op_selected;
    logic [W:0]     number_out;
    logic           special_signal;

    exp_t exp_q[$];
    int   checks;
    int   errors;

    // Reference state: what the output registers should hold.
    longint ref_out;
    bit     ref_sign;

    calc_alu #(
        .DATA_W (W)
    ) dut (
        .clk            (clk),
        .clear          (clear),
        .num1           (num1),
        .num2           (num2),
        .op_selected    (op_selected),
        .number_out     (number_out),
        .special_signal (special_signal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W:0] got_o, input logic got_s,
                         input logic [W:0] exp_o, input logic exp_s);
        checks++;
        if (got_o !== exp_o || got_s !== exp_s) begin
            errors++;
            $display("FAIL %s: got out=0x%0h sign=%0b, expected out=0x%0h sign=%0b",
                     name, got_o, got_s, exp_o, exp_s);
        end
    endtask

    // Arithmetic reference: next register contents from plain integer rules.
    task automatic model(input bit clr, input int op, input longint a, input longint b);
        longint modv;
        modv = longint'(1) << (W + 1);
        if (!clr) begin
            ref_out  = 0;
            ref_sign = 0;
        end else if (op == 1) begin
            ref_out  = a + b;
            ref_sign = 0;
        end else if (op == 2) begin
`ifdef CALC_ALU_SIGNMAG_EN
            ref_out  = (a >= b) ? a - b : b - a;
`else
            ref_out  = (a - b + modv) % modv;
`endif
            ref_sign = (a < b);
        end else if (op == 3) begin
            ref_out  = 0;
            ref_sign = 0;
        end
    endtask

    // Drive one cycle of stimulus at the falling edge and queue the expectation.
    task automatic cycle(input string name, input bit clr, input int op,
                         input int a, input int b);
        exp_t e;
        @(negedge clk);
        clear       = clr;
        op_selected = op[1:0];
        num1        = a[W-1:0];
        num2        = b[W-1:0];
        model(clr, op, longint'(a), longint'(b));
        e.out  = ref_out[W:0];
        e.sign = ref_sign;
        e.name = name;
        exp_q.push_back(e);
    endtask

    // Assert reset between edges; outputs must clear without any clock edge and
    // the result queued for the upcoming edge is discarded.
    task automatic async_reset(input string name);
        #2;
        clear = 1'b0;
        #1;
        check(name, number_out, special_signal, '0, 1'b0);
        ref_out  = 0;
        ref_sign = 0;
        if (exp_q.size() > 0) begin
            exp_q[exp_q.size() - 1].out  = '0;
            exp_q[exp_q.size() - 1].sign = 1'b0;
        end
    endtask

    // Monitor: compare registered outputs just after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check(e.name, number_out, special_signal, e.out, e.sign);
            end
        end
    end

    initial begin
        int op, a, b;
        checks      = 0;
        errors      = 0;
        ref_out     = 0;
        ref_sign    = 0;
        clear       = 1'b0;
        num1        = 16'd1234;
        num2        = 16'd77;
        op_selected = 2'b01;
        #1;
        check("reset_initial", number_out, special_signal, '0, 1'b0);

        // Held in reset across an edge with nonzero inputs.
        cycle("reset_held", 1'b0, 1, 1234, 77);
        // Release: first edge loads the current opcode.
        cycle("reset_release_add", 1'b1, 1, 1234, 77);

        cycle("add_5_3", 1'b1, 1, 5, 3);
        cycle("add_carry", 1'b1, 1, 65535, 1);
        cycle("sub_10_7", 1'b1, 2, 10, 7);
        cycle("sub_26_16", 1'b1, 2, 26, 16);
        cycle("sub_16_26", 1'b1, 2, 16, 26);
        cycle("sub_26_16_flag_clears", 1'b1, 2, 26, 16);
        cycle("sub_16_26_again", 1'b1, 2, 16, 26);
        cycle("rsv_after_sub", 1'b1, 3, 16, 26);
        cycle("add_5_3_again", 1'b1, 1, 5, 3);
        for (int i = 0; i < 4; i++) cycle("nop_hold", 1'b1, 0, 999, 12);
        cycle("sub_equal", 1'b1, 2, 100, 100);
        cycle("sub_0_65535", 1'b1, 2, 0, 65535);
        cycle("nop_hold_neg", 1'b1, 0, 1, 2);

        // Mid-operation reset discards the pending ADD.
        cycle("add_pending", 1'b1, 1, 40000, 30000);
        async_reset("async_clear_now");
        cycle("release_sub", 1'b1, 2, 3, 9);

        for (int i = 0; i < 400; i++) begin
            op = int'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       a = 0;
                1:       a = 65535;
                default: a = int'($urandom_range(0, 65535));
            endcase
            b = ($urandom_range(0, 7) == 0) ? a : int'($urandom_range(0, 65535));
            if ($urandom_range(0, 39) == 0) begin
                cycle("rand_pending", 1'b1, op, a, b);
                async_reset("rand_async_clear");
            end else begin
                cycle("rand", 1'b1, op, a, b);
            end
        end

        // Let the monitor drain; an undrained queue counts as a failure.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results still pending, expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/calc_alu.md
CALC_ALU -- requirements
Module: calc_alu

Interface
REQ-001 Parameter DATA_W, default 16, operand width; result width is DATA_W+1.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 clear  input  1  reset, asynchronous, active-low.
REQ-004 num1  input  DATA_W  first operand, unsigned.
REQ-005 num2  input  DATA_W  second operand, unsigned.
REQ-006 op_selected  input  2  opcode: 00 NOP, 01 ADD, 10 SUB, 11 reserved.
REQ-007 number_out  output  DATA_W+1  registered result, unsigned magnitude.
REQ-008 special_signal  output  1  registered sign flag; 1 = SUB result negative.

Function
REQ-009 Outputs SHALL be registered; each result SHALL appear one rising clk edge after operands/opcode are sampled.
REQ-010 Inputs SHALL be sampled every cycle; no handshake, no enable.
REQ-011 ADD (01): number_out SHALL equal zero-extended num1 + num2, full DATA_W+1 width with no wrap, and special_signal SHALL be 0.
REQ-012 The ADD carry SHALL appear in number_out[DATA_W], so 65535+1 gives 65536.
REQ-013 SUB (10), num1 >= num2: number_out SHALL be num1 - num2 and special_signal SHALL be 0.
REQ-014 SUB (10), num1 < num2: number_out SHALL be num2 - num1 and special_signal SHALL be 1.
REQ-015 SUB with equal operands SHALL give number_out 0 and special_signal 0.
REQ-016 SUB results SHALL always have number_out[DATA_W] = 0.
REQ-017 NOP (00): number_out and special_signal SHALL hold their previous values.
REQ-018 Reserved (11): number_out SHALL load 0 and special_signal SHALL load 0 on the next edge.
REQ-019 Changing the opcode or operands SHALL take effect on the next edge, with no residue from the previous operation.

Reset
REQ-020 While clear = 0, number_out SHALL be 0 and special_signal SHALL be 0 immediately, independent of clk.
REQ-021 Reset asserted mid-operation SHALL discard the pending result.
REQ-022 On the first rising edge after clear deasserts, the registers SHALL load per the current opcode.
REQ-023 Reset deassertion SHALL be treated as asynchronous, with no internal synchronizer.

Configuration
REQ-024 Macro CALC_ALU_SIGNMAG_EN, defined: SUB SHALL behave per REQ-013..REQ-016 (magnitude plus sign flag).
REQ-025 Macro CALC_ALU_SIGNMAG_EN, undefined:
- SUB SHALL output the (DATA_W+1)-bit two's-complement of num1 - num2.
- special_signal SHALL equal the borrow (num1 < num2).
- Example: 16 - 26 gives 0x1FFF6 with special_signal 1.
REQ-026 ADD, NOP, reserved and reset behaviour SHALL be identical with or without the macro.

Structure
REQ-027 Shared package calc_alu_pkg SHALL hold:
- opcode typedef with OP_NOP = 2'b00, OP_ADD = 2'b01, OP_SUB = 2'b10, OP_RSV = 2'b11;
- DATA_W default constant.
REQ-028 Combinational add/subtract/magnitude/sign logic SHALL live in one sub-module, calc_alu_addsub.
REQ-029 The top module SHALL contain only opcode decode and the output registers.

Verification
REQ-030 Reset: clear = 0 with nonzero inputs -> number_out = 0, special_signal = 0 with no clk edge; release -> next edge loads the result.
REQ-031 ADD 5 + 3 -> number_out = 8, special_signal = 0 one edge later; ADD 65535 + 1 -> 65536, bit 16 set.
REQ-032 SUB 10 - 7 -> 3, sign 0; SUB 26 - 16 -> 10, sign 0; SUB 16 - 26 -> 10, sign 1; then SUB 26 - 16 -> 10, sign 0 (flag clears).
REQ-033 Opcode 11 after SUB 16 - 26 -> number_out = 0, special_signal = 0; opcode 00 after ADD 5 + 3 -> holds 8 over several edges.
REQ-034 SUB 100 - 100 -> 0, sign 0; SUB 0 - 65535 -> 65535, sign 1.
REQ-035 Macro undefined: SUB 16 - 26 -> 0x1FFF6, special_signal 1; SUB 10 - 7 -> 3, special_signal 0.
